cpu_execute: RTL and testbench
==============================

CPU_EXECUTE -- requirements
Module: CPU_execute

Interface
REQ-001 clock  in  1  single core clock; all state updates on posedge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 next_PC, ra_data, rb_data, offset_data  in  32 each  operands from decode pipeline register.
REQ-004 reg_dest  in  5  destination register id; alu_op  in  2  ALU_ADD_OP/ALU_SUB_OP/ALU_AND_OP/ALU_OR_OP per CPU_define.vh; use_reg_b  in  1  selects rb_data (1) or offset_data (0).
REQ-005 mul_op  in  1  multiply request; branch, jump, mem_read, mem_write, mem_to_reg, reg_write  in  1 each  control bits from decode.
REQ-006 flush  in  1  commit-stage redirect; kill current work.
REQ-007 c_alu_result, c_store_data, c_branch_target  out  32 each; c_reg_dest  out  5; c_taken, c_mem_read, c_mem_write, c_mem_to_reg, c_reg_write  out  1 each (registered, to commit stage).
REQ-008 stall  out  1  to hazard unit; decode and fetch hold while high.

Function
REQ-009 When idle and not flushed, the block SHALL register all c_* outputs every posedge (1-cycle latency).
REQ-010 operand B SHALL be use_reg_b ? rb_data : offset_data; c_alu_result SHALL be ra_data op B, 32-bit, wrap-around, no flags beyond zero.
REQ-011 c_branch_target SHALL be next_PC + offset_data (mod 2^32) for branch, and ALU result (ra_data + offset_data) for jump.
REQ-012 c_taken SHALL be branch & (jump | (ra_data - rb_data == 0)); 0 when branch=0.
REQ-013 c_store_data SHALL be rb_data; control outputs SHALL copy inputs; c_reg_dest SHALL copy reg_dest.
REQ-014 multiplier FSM states IDLE, BUSY, DONE; IDLE -> BUSY on mul_op=1 and flush=0, capturing ra_data, rb_data, reg_dest.
REQ-015 BUSY: shift-add radix-2, one multiplier bit per cycle, 5-bit counter 0..31; BUSY -> DONE after iteration 31.
REQ-016 DONE: outputs low 32 bits of product on c_alu_result, c_reg_write=1, c_reg_dest=captured id, other control 0; DONE -> IDLE next cycle.
REQ-017 stall SHALL be 1 combinationally in BUSY and in IDLE while mul_op=1; 0 in DONE; total result latency = 33 cycles from accept.
REQ-018 During BUSY the block SHALL drive a bubble (all c_* control bits 0) and ignore all inputs except flush.
REQ-019 flush SHALL take priority over all events: next outputs are a bubble, FSM returns to IDLE, stall drops combinationally, mul_op in same cycle is not accepted.
REQ-020 Multiply of 0 or 0xFFFFFFFF operands SHALL produce the exact low 32 bits of the unsigned product (equal to signed low word).

Reset
REQ-021 On reset all c_* outputs SHALL be 0, FSM IDLE, counter 0, stall 0; reset mid-multiply SHALL discard the operation with no write.
REQ-022 First posedge after reset release SHALL behave as normal IDLE operation.

Configuration
REQ-023 Macro CPU_MUL_EN: defined -> REQ-014..REQ-020 multiplier present.
REQ-024 Undefined -> no FSM or multiplier logic; mul_op treated as a bubble (c_reg_write=0), stall tied 0.

Verification
REQ-025 ADD ra=0xFFFFFFFF, offset=2, use_reg_b=0, reg_write=1 -> next cycle c_alu_result=0x00000001, c_reg_write=1.
REQ-026 BEQ ra=rb=7, next_PC=0x100, offset=0x20 -> c_taken=1, c_branch_target=0x120; ra=7, rb=8 -> c_taken=0.
REQ-027 MUL ra=12345, rb=678 (CPU_MUL_EN) -> stall high 32 cycles, then c_alu_result=8369910, c_reg_write=1 for exactly one cycle.
REQ-028 flush at BUSY iteration 10 -> next output bubble, stall 0, no c_reg_write; following ADD handled normally.
REQ-029 reset asserted at BUSY iteration 20 -> all outputs 0 immediately, no multiply result ever emitted.
REQ-030 CPU_MUL_EN undefined, MUL issued -> stall stays 0, next cycle c_reg_write=0.

Source files
------------

// File: rtl/cpu_execute.sv
// -----------------------------------------------------------------------------
// cpu_execute
//   Execute stage of a simple in-order pipeline. Computes the ALU result,
//   branch target and taken flag for the instruction held in the decode
//   pipeline register, and registers them with the control bits towards the
//   commit stage (one-cycle latency).
//
//   Optional multiplier (enabled by defining CPU_MUL_EN): a radix-2 shift-add
//   unit that retires one multiplier bit per cycle. While it works the stage
//   emits bubbles and raises stall. Without CPU_MUL_EN a multiply request is
//   turned into a bubble and stall is tied low.
//
// Ports
//   clock, reset         core clock; asynchronous active-high reset
//   next_PC, ra_data,    32-bit operands from decode
//   rb_data, offset_data
//   reg_dest             destination register id
//   alu_op               0 add, 1 sub, 2 and, 3 or
//   use_reg_b            1: operand B = rb_data, 0: operand B = offset_data
//   mul_op               multiply request
//   branch, jump, mem_read, mem_write, mem_to_reg, reg_write
//                        control bits from decode
//   flush                commit-stage redirect, kills current work
//   c_*                  registered results/control to commit
//   stall                decode/fetch hold request (combinational)
// -----------------------------------------------------------------------------
module cpu_execute (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] next_PC,
    input  logic [31:0] ra_data,
    input  logic [31:0] rb_data,
    input  logic [31:0] offset_data,
    input  logic [4:0]  reg_dest,
    input  logic [1:0]  alu_op,
    input  logic        use_reg_b,
    input  logic        mul_op,
    input  logic        branch,
    input  logic        jump,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic        reg_write,
    input  logic        flush,
    output logic [31:0] c_alu_result,
    output logic [31:0] c_store_data,
    output logic [31:0] c_branch_target,
    output logic [4:0]  c_reg_dest,
    output logic        c_taken,
    output logic        c_mem_read,
    output logic        c_mem_write,
    output logic        c_mem_to_reg,
    output logic        c_reg_write,
    output logic        stall
);

    localparam logic [1:0] ALU_ADD_OP = 2'd0;
    localparam logic [1:0] ALU_SUB_OP = 2'd1;
    localparam logic [1:0] ALU_AND_OP = 2'd2;
    localparam logic [1:0] ALU_OR_OP  = 2'd3;

    function automatic logic [31:0] alu_fn(input logic [1:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_ADD_OP: r = a + b;
            ALU_SUB_OP: r = a - b;
            ALU_AND_OP: r = a & b;
            ALU_OR_OP:  r = a | b;
            default:    r = a + b;
        endcase
        return r;
    endfunction

    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [31:0] br_target;
    logic        taken;

    assign op_b      = use_reg_b ? rb_data : offset_data;
    assign alu_res   = alu_fn(alu_op, ra_data, op_b);
    // Jumps use the base register as target base, branches are PC-relative.
    assign br_target = jump ? (ra_data + offset_data) : (next_PC + offset_data);
    assign taken     = branch & (jump | ((ra_data - rb_data) == 32'd0));

    logic        mul_bubble;   // force control bits of the next output low
    logic        mul_done;     // next output carries the multiply result
    logic [31:0] mul_result;
    logic [4:0]  mul_dest;

`ifdef CPU_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [4:0]  dest_q;
    logic        accept;

    assign accept = (state == IDLE) && mul_op && !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (mul_op) state_nxt = BUSY;
                BUSY:    if (cnt == 5'd31) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        stall = !flush && ((state == BUSY) || ((state == IDLE) && mul_op));
    end

    // Shift-add datapath: only the low 32 product bits are ever needed, so the
    // multiplicand shifts left inside a 32-bit register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt    <= 5'd0;
            mcand  <= 32'd0;
            mplier <= 32'd0;
            acc    <= 32'd0;
            dest_q <= 5'd0;
        end else if (accept) begin
            cnt    <= 5'd0;
            mcand  <= ra_data;
            mplier <= rb_data;
            acc    <= 32'd0;
            dest_q <= reg_dest;
        end else if (flush) begin
            cnt    <= 5'd0;
        end else if (state == BUSY) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
        end
    end

    assign mul_bubble = flush || accept || (state == BUSY);
    assign mul_done   = (state == DONE) && !flush;
    assign mul_result = acc;
    assign mul_dest   = dest_q;
`else
    assign stall      = 1'b0;
    assign mul_bubble = flush || mul_op;
    assign mul_done   = 1'b0;
    assign mul_result = 32'd0;
    assign mul_dest   = 5'd0;
`endif

    // ---- execute -> commit register ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            c_alu_result    <= 32'd0;
            c_store_data    <= 32'd0;
            c_branch_target <= 32'd0;
            c_reg_dest      <= 5'd0;
            c_taken         <= 1'b0;
            c_mem_read      <= 1'b0;
            c_mem_write     <= 1'b0;
            c_mem_to_reg    <= 1'b0;
            c_reg_write     <= 1'b0;
        end else if (mul_done) begin
            c_alu_result    <= mul_result;
            c_store_data    <= 32'd0;
            c_branch_target <= 32'd0;
            c_reg_dest      <= mul_dest;
            c_taken         <= 1'b0;
            c_mem_read      <= 1'b0;
            c_mem_write     <= 1'b0;
            c_mem_to_reg    <= 1'b0;
            c_reg_write     <= 1'b1;
        end else begin
            c_alu_result    <= alu_res;
            c_store_data    <= rb_data;
            c_branch_target <= br_target;
            c_reg_dest      <= reg_dest;
            c_taken         <= taken      & !mul_bubble;
            c_mem_read      <= mem_read   & !mul_bubble;
            c_mem_write     <= mem_write  & !mul_bubble;
            c_mem_to_reg    <= mem_to_reg & !mul_bubble;
            c_reg_write     <= reg_write  & !mul_bubble;
        end
    end

endmodule

// File: tb/tb_cpu_execute.sv
// -----------------------------------------------------------------------------
// tb_cpu_execute
//   Directed self-checking bench for cpu_execute. Expected results come from a
//   small behavioural model, are queued when an instruction is driven and
//   compared when the stage registers its output. Multiplier scenarios are
//   compiled only when CPU_MUL_EN is defined.
// -----------------------------------------------------------------------------
module tb_cpu_execute;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] next_PC = '0, ra_data = '0, rb_data = '0, offset_data = '0;
    logic [4:0]  reg_dest = '0;
    logic [1:0]  alu_op = '0;
    logic        use_reg_b = 1'b0, mul_op = 1'b0, branch = 1'b0, jump = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0;
    logic        reg_write = 1'b0, flush = 1'b0;
    logic [31:0] c_alu_result, c_store_data, c_branch_target;
    logic [4:0]  c_reg_dest;
    logic        c_taken, c_mem_read, c_mem_write, c_mem_to_reg, c_reg_write;
    logic        stall;

    cpu_execute dut (
        .clock(clock), .reset(reset),
        .next_PC(next_PC), .ra_data(ra_data), .rb_data(rb_data),
        .offset_data(offset_data), .reg_dest(reg_dest), .alu_op(alu_op),
        .use_reg_b(use_reg_b), .mul_op(mul_op), .branch(branch), .jump(jump),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .flush(flush),
        .c_alu_result(c_alu_result), .c_store_data(c_store_data),
        .c_branch_target(c_branch_target), .c_reg_dest(c_reg_dest),
        .c_taken(c_taken), .c_mem_read(c_mem_read), .c_mem_write(c_mem_write),
        .c_mem_to_reg(c_mem_to_reg), .c_reg_write(c_reg_write), .stall(stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] store;
        logic [31:0] tgt;
        logic [4:0]  dest;
        logic [4:0]  ctl;   // {taken, mem_read, mem_write, mem_to_reg, reg_write}
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [4:0] obs_ctl();
        return {c_taken, c_mem_read, c_mem_write, c_mem_to_reg, c_reg_write};
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of a normal (non-multiplier) instruction.
    function automatic exp_t model();
        exp_t        m;
        logic [31:0] b;
        logic        tk;
        logic        bub;
        b = use_reg_b ? rb_data : offset_data;
        case (alu_op)
            2'd0: m.alu = ra_data + b;
            2'd1: m.alu = ra_data + ~b + 32'd1;
            2'd2: m.alu = ra_data & b;
            default: m.alu = ra_data | b;
        endcase
        m.store = rb_data;
        m.tgt   = jump ? ra_data + offset_data : next_PC + offset_data;
        m.dest  = reg_dest;
        tk      = branch && (jump || (ra_data == rb_data));
        bub     = flush || mul_op;
        m.ctl   = bub ? 5'd0 : {tk, mem_read, mem_write, mem_to_reg, reg_write};
        return m;
    endfunction

    task automatic compare_out(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            cmp({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            cmp({tag, "_alu"},   c_alu_result,    e.alu);
            cmp({tag, "_store"}, c_store_data,    e.store);
            cmp({tag, "_tgt"},   c_branch_target, e.tgt);
            cmp({tag, "_dest"},  {27'd0, c_reg_dest}, {27'd0, e.dest});
            cmp({tag, "_ctl"},   {27'd0, obs_ctl()},  {27'd0, e.ctl});
        end
    endtask

    // Drive-side push, then one clock, then output-side pop/compare.
    task automatic step(input string tag);
        sbq.push_back(model());
        cmp({tag, "_stall"}, {31'd0, stall}, 32'd0);
        @(posedge clock); #1;
        compare_out(tag);
    endtask

    task automatic clr();
        next_PC = '0; ra_data = '0; rb_data = '0; offset_data = '0;
        reg_dest = '0; alu_op = '0; use_reg_b = 0; mul_op = 0; branch = 0;
        jump = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 0;
        flush = 0;
    endtask

`ifdef CPU_MUL_EN
    // Issue a multiply, hold it while stalled, and check timing and result.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        int   n;
        exp_t e;
        e.alu = a * b; e.store = 32'd0; e.tgt = 32'd0; e.dest = d; e.ctl = 5'b00001;
        sbq.push_back(e);
        clr(); mul_op = 1; ra_data = a; rb_data = b; reg_dest = d; reg_write = 1;
        #1 cmp("mul_stall_accept", {31'd0, stall}, 32'd1);
        @(posedge clock); #1;
        n = 0;
        while (stall && n < 40) begin
            cmp("mul_busy_bubble", {27'd0, obs_ctl()}, 32'd0);
            n++;
            @(posedge clock); #1;
        end
        cmp("mul_stall_cycles", n, 32);
        cmp("mul_done_no_early_write", {31'd0, c_reg_write}, 32'd0);
        @(posedge clock); #1;
        compare_out("mul_result");
        clr();
        step("mul_single_pulse");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        cmp("rst_alu",   c_alu_result, 32'd0);
        cmp("rst_tgt",   c_branch_target, 32'd0);
        cmp("rst_store", c_store_data, 32'd0);
        cmp("rst_ctl",   {27'd0, obs_ctl()}, 32'd0);
        cmp("rst_dest",  {27'd0, c_reg_dest}, 32'd0);
        cmp("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clock); reset = 0;

        // ADD wrap-around with immediate
        clr(); ra_data = 32'hFFFF_FFFF; offset_data = 32'd2; reg_write = 1; reg_dest = 5'd3;
        step("add_wrap");
        // SUB with register operand
        clr(); alu_op = 2'd1; use_reg_b = 1; ra_data = 32'd5; rb_data = 32'd7; reg_write = 1; reg_dest = 5'd4;
        step("sub_reg");
        // AND / OR
        clr(); alu_op = 2'd2; use_reg_b = 1; ra_data = 32'hF0F0_1234; rb_data = 32'h0FF0_FF00; reg_write = 1;
        step("and_reg");
        clr(); alu_op = 2'd3; ra_data = 32'hA000_0005; offset_data = 32'h0500_0030; reg_write = 1; reg_dest = 5'd31;
        step("or_imm");
        // BEQ taken / not taken
        clr(); branch = 1; ra_data = 32'd7; rb_data = 32'd7; next_PC = 32'h100; offset_data = 32'h20;
        step("beq_taken");
        clr(); branch = 1; ra_data = 32'd7; rb_data = 32'd8; next_PC = 32'h100; offset_data = 32'h20;
        step("beq_not_taken");
        // Jump: target based on ra, always taken
        clr(); branch = 1; jump = 1; ra_data = 32'h1000; rb_data = 32'd9; next_PC = 32'h40; offset_data = 32'h10;
        step("jump");
        // Branch target wraps mod 2^32
        clr(); branch = 1; ra_data = 32'd1; rb_data = 32'd1; next_PC = 32'hFFFF_FFF0; offset_data = 32'h20;
        step("beq_wrap");
        // Load / store control copy
        clr(); mem_read = 1; mem_to_reg = 1; reg_write = 1; ra_data = 32'h200; offset_data = 32'h8; reg_dest = 5'd12;
        step("load");
        clr(); mem_write = 1; ra_data = 32'h300; rb_data = 32'hDEAD_BEEF; offset_data = 32'h4;
        step("store");
        // Flush kills the instruction
        clr(); flush = 1; reg_write = 1; mem_write = 1; branch = 1; ra_data = 32'd3; rb_data = 32'd3;
        step("flush_bubble");
        clr(); ra_data = 32'd10; offset_data = 32'd20; reg_write = 1; reg_dest = 5'd2;
        step("after_flush");

`ifdef CPU_MUL_EN
        run_mul(32'd12345, 32'd678, 5'd9);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10);
        run_mul(32'd0, 32'hFFFF_FFFF, 5'd11);

        // Flush during BUSY iteration 10
        clr(); mul_op = 1; ra_data = 32'd55; rb_data = 32'd66; reg_dest = 5'd5; reg_write = 1;
        @(posedge clock); #1;
        repeat (10) @(posedge clock);
        #1 flush = 1;
        #1 cmp("mulflush_stall_drop", {31'd0, stall}, 32'd1 - 32'd1);
        @(posedge clock); #1;
        cmp("mulflush_bubble", {27'd0, obs_ctl()}, 32'd0);
        clr(); ra_data = 32'd100; offset_data = 32'd1; reg_write = 1; reg_dest = 5'd6;
        step("mulflush_add");
        begin
            int hits = 0;
            clr();
            repeat (40) begin
                @(posedge clock); #1;
                if (c_reg_write) hits++;
            end
            cmp("mulflush_no_write", hits, 0);
        end

        // Reset during BUSY iteration 20
        clr(); mul_op = 1; ra_data = 32'd77; rb_data = 32'd88; reg_dest = 5'd7; reg_write = 1;
        @(posedge clock); #1;
        repeat (20) @(posedge clock);
        #1 reset = 1;
        #1 cmp("mulrst_ctl", {27'd0, obs_ctl()}, 32'd0);
        cmp("mulrst_alu",   c_alu_result, 32'd0);
        cmp("mulrst_stall", {31'd0, stall}, 32'd0);
        clr();
        @(negedge clock); reset = 0;
        begin
            int hits = 0;
            repeat (40) begin
                @(posedge clock); #1;
                if (c_reg_write) hits++;
            end
            cmp("mulrst_no_write", hits, 0);
        end
`else
        // Without the multiplier a MUL is a bubble and never stalls
        clr(); mul_op = 1; reg_write = 1; ra_data = 32'd12345; rb_data = 32'd678; reg_dest = 5'd9;
        step("mul_disabled");
`endif

        // Reset between edges clears outputs immediately
        clr(); ra_data = 32'd1; offset_data = 32'd1; reg_write = 1; reg_dest = 5'd8;
        step("pre_reset");
        #1 reset = 1;
        #1 cmp("async_rst_ctl", {27'd0, obs_ctl()}, 32'd0);
        cmp("async_rst_alu",  c_alu_result, 32'd0);
        cmp("async_rst_dest", {27'd0, c_reg_dest}, 32'd0);
        #1 reset = 0;
        // First edge after release behaves as normal operation
        clr(); alu_op = 2'd1; ra_data = 32'd0; offset_data = 32'd1; reg_write = 1; reg_dest = 5'd1;
        step("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
